// File: rtl/fact_datapath.sv
// ---------------------------------------------------------------------------
// fact_datapath
//
// Datapath for the iterative factorial engine. The factorial controller
// drives it. It holds the down-counter A, the fixed comparison operand B = 1
// and the running product P. Each accepted step runs one shift-add multiply,
// P <= P * A, taking one clock per multiplier bit. After that, A is
// decremented.
//
// Parameters:
//   N_W  width of operand n and counter A (default 4)
//   P_W  width of product register and result (default 32)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   n       in   factorial operand, sampled only when ld=1
//   ld      in   load: A <= max(n,1), P <= 1, ovf <= 0, aborts any multiply
//   step    in   request one multiply-and-decrement iteration
//   a_ne_b  out  A != 1, combinational from A
//   busy    out  a multiply iteration is in progress
//   ovf     out  sticky overflow flag
//   result  out  current value of P
//
// Optional feature macro: FACT_OVF_SAT_EN
//   When it is defined, P saturates to all-ones once an overflow has been
//   seen. When it is undefined, P keeps the product modulo 2^P_W.
// ---------------------------------------------------------------------------
module fact_datapath #(
    parameter int N_W = 4,
    parameter int P_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N_W-1:0] n,
    input  logic           ld,
    input  logic           step,
    output logic           a_ne_b,
    output logic           busy,
    output logic           ovf,
    output logic [P_W-1:0] result
);

    localparam int M_W = P_W + N_W;
    localparam int C_W = (N_W > 1) ? $clog2(N_W) : 1;
    localparam logic [C_W-1:0] LAST_BIT = C_W'(N_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        UPD
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [N_W-1:0] a;
    logic [P_W-1:0] p;
    logic           ovf_flag;
    logic [M_W-1:0] acc;
    logic [M_W-1:0] mcand;
    logic [N_W-1:0] mplier;
    logic [C_W-1:0] bit_cnt;
    logic           start;
    logic           prod_ovf;

    assign a_ne_b   = (a != N_W'(1));
    assign busy     = (state != IDLE);
    assign ovf      = ovf_flag;
    assign result   = p;
    // A step is taken only from IDLE, only when A != 1, and only when ld is low.
    assign start    = (state == IDLE) && !ld && step && a_ne_b;
    // Any bit of the product above P_W means the result no longer fits.
    assign prod_ovf = |acc[M_W-1:P_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. ld wins over everything and always returns to IDLE,
    // so a multiply in flight is abandoned without touching P or A.
    always_comb begin
        next_state = state;
        if (ld) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = MUL;
                MUL:     if (bit_cnt == LAST_BIT) next_state = UPD;
                UPD:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath registers. The multiply is a plain shift-add: one multiplier
    // bit per clock, with the multiplicand shifting left. A finished product
    // is committed to P only in UPD, so an abort leaves P and A untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= N_W'(1);
            p        <= P_W'(1);
            ovf_flag <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bit_cnt  <= '0;
        end else if (ld) begin
            a        <= (n == '0) ? N_W'(1) : n;
            p        <= P_W'(1);
            ovf_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        mcand   <= M_W'(p);
                        mplier  <= a;
                        bit_cnt <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + C_W'(1);
                end
                UPD: begin
                    if (prod_ovf) begin
                        ovf_flag <= 1'b1;
                    end
`ifdef FACT_OVF_SAT_EN
                    p <= (prod_ovf || ovf_flag) ? {P_W{1'b1}} : acc[P_W-1:0];
`else
                    p <= acc[P_W-1:0];
`endif
                    a <= a - N_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_datapath.sv
// ---------------------------------------------------------------------------
// tb_fact_datapath
//
// Self-checking bench for fact_datapath, built with N_W=4 and P_W=16 so that
// overflow can be reached. The reference model is an arithmetic model: the
// next P is the previous P times A, using wide integers. Overflow is flagged
// when that true product does not fit in P_W bits.
// ---------------------------------------------------------------------------
module tb_fact_datapath;

    localparam int N_W = 4;
    localparam int P_W = 16;
    localparam longint PMOD = 64'd1 << P_W;

    logic           clk;
    logic           rst;
    logic [N_W-1:0] n;
    logic           ld;
    logic           step;
    logic           a_ne_b;
    logic           busy;
    logic           ovf;
    logic [P_W-1:0] result;

    int n_pass;
    int n_total;

    // Reference model state
    int     m_a;
    longint m_p;
    logic   m_ovf;

    fact_datapath #(.N_W(N_W), .P_W(P_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .n      (n),
        .ld     (ld),
        .step   (step),
        .a_ne_b (a_ne_b),
        .busy   (busy),
        .ovf    (ovf),
        .result (result)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle 1 unit past it for driving and sampling.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_load(input int nv);
        m_a   = (nv <= 1) ? 1 : nv;
        m_p   = 1;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step();
        longint prod;
        prod = m_p * longint'(m_a);
        if (prod >= PMOD) m_ovf = 1'b1;
`ifdef FACT_OVF_SAT_EN
        m_p = m_ovf ? (PMOD - 1) : prod;
`else
        m_p = prod % PMOD;
`endif
        m_a = m_a - 1;
    endfunction

    task automatic do_load(input int nv);
        n  = N_W'(nv);
        ld = 1'b1;
        cycle();
        ld = 1'b0;
        model_load(nv);
    endtask

    // One accepted step. Stray step pulses are sent while busy, and the
    // busy duration, result and ovf are checked against the model.
    task automatic do_step();
        int cnt;
        repeat ($urandom_range(0, 2)) cycle();
        n_total++;
        if (a_ne_b !== (m_a != 1)) $display("[TB] FAIL step_a_ne_b: got %0b want %0b", a_ne_b, (m_a != 1));
        else n_pass++;
        step = 1'b1;
        cycle();
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            step = 1'($urandom_range(0, 1));
            cycle();
            cnt++;
        end
        step = 1'b0;
        model_step();
        n_total++;
        if (cnt != N_W + 1) $display("[TB] FAIL step_busy_len: got %0d want %0d", cnt, N_W + 1);
        else n_pass++;
        n_total++;
        if (result !== P_W'(m_p)) $display("[TB] FAIL step_result: got %0d want %0d", result, P_W'(m_p));
        else n_pass++;
        n_total++;
        if (ovf !== m_ovf) $display("[TB] FAIL step_ovf: got %0b want %0b", ovf, m_ovf);
        else n_pass++;
    endtask

    task automatic run_to_completion();
        int guard;
        guard = 0;
        while (m_a != 1 && guard < 16) begin
            do_step();
            guard++;
        end
        n_total++;
        if (a_ne_b !== 1'b0) $display("[TB] FAIL done_a_ne_b: got %0b want 0", a_ne_b);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        model_load(1);
        n_total++;
        if ({result, a_ne_b, busy, ovf} !== {P_W'(1), 3'b000})
            $display("[TB] FAIL reset_state: got r=%0d a_ne_b=%0b busy=%0b ovf=%0b want r=1 0 0 0",
                     result, a_ne_b, busy, ovf);
        else n_pass++;
    endtask

    task automatic test_fact5();
        int steps;
        do_load(5);
        steps = 0;
        while (a_ne_b === 1'b1 && steps < 10) begin
            do_step();
            steps++;
        end
        n_total++;
        if (steps != 4) $display("[TB] FAIL fact5_steps: got %0d want 4", steps);
        else n_pass++;
        n_total++;
        if ({result, a_ne_b, ovf} !== {P_W'(120), 2'b00})
            $display("[TB] FAIL fact5_final: got r=%0d a_ne_b=%0b ovf=%0b want r=120 0 0", result, a_ne_b, ovf);
        else n_pass++;
    endtask

    task automatic test_small_n();
        for (int v = 0; v < 2; v++) begin
            do_load(v);
            n_total++;
            if ({result, a_ne_b} !== {P_W'(1), 1'b0})
                $display("[TB] FAIL small_n_load: n=%0d got r=%0d a_ne_b=%0b want r=1 0", v, result, a_ne_b);
            else n_pass++;
        end
        step = 1'b1;
        cycle();
        step = 1'b0;
        n_total++;
        if ({busy, result} !== {1'b0, P_W'(1)})
            $display("[TB] FAIL small_n_step: got busy=%0b r=%0d want busy=0 r=1", busy, result);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_load(3);
        step = 1'b1;
        cycle();
        step = 1'b0;
        for (int j = 0; j < N_W + 1; j++) begin
            n_total++;
            if (busy !== 1'b1) $display("[TB] FAIL latency_busy: cycle %0d got %0b want 1", j, busy);
            else n_pass++;
            step = (j == 1);
            cycle();
            step = 1'b0;
        end
        model_step();
        n_total++;
        if ({busy, result, a_ne_b} !== {1'b0, P_W'(3), 1'b1})
            $display("[TB] FAIL latency_done: got busy=%0b r=%0d a_ne_b=%0b want busy=0 r=3 a_ne_b=1",
                     busy, result, a_ne_b);
        else n_pass++;
    endtask

    task automatic test_abort();
        do_load(6);
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        do_load(4);
        n_total++;
        if ({busy, result, a_ne_b, ovf} !== {1'b0, P_W'(1), 1'b1, 1'b0})
            $display("[TB] FAIL abort_state: got busy=%0b r=%0d a_ne_b=%0b ovf=%0b want 0 1 1 0",
                     busy, result, a_ne_b, ovf);
        else n_pass++;
        run_to_completion();
        n_total++;
        if (result !== P_W'(24)) $display("[TB] FAIL abort_final: got %0d want 24", result);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_load(9);
        for (int s = 1; s <= 8; s++) begin
            do_step();
            n_total++;
            if (ovf !== (s >= 7)) $display("[TB] FAIL ovf_step%0d: got %0b want %0b", s, ovf, (s >= 7));
            else n_pass++;
        end
        n_total++;
`ifdef FACT_OVF_SAT_EN
        if (result !== 16'hFFFF) $display("[TB] FAIL ovf_final: got %0d want 65535", result);
`else
        if (result !== 16'd35200) $display("[TB] FAIL ovf_final: got %0d want 35200", result);
`endif
        else n_pass++;
    endtask

    task automatic test_reset_in_upd();
        do_load(9);
        for (int s = 0; s < 7; s++) do_step();
        step = 1'b1;
        cycle();
        step = 1'b0;
        repeat (N_W) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_load(1);
        n_total++;
        if ({busy, result, ovf, a_ne_b} !== {1'b0, P_W'(1), 2'b00})
            $display("[TB] FAIL reset_upd: got busy=%0b r=%0d ovf=%0b a_ne_b=%0b want 0 1 0 0",
                     busy, result, ovf, a_ne_b);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            // ld together with a possible step: the step must be dropped.
            n    = N_W'($urandom_range(0, 15));
            ld   = 1'b1;
            step = 1'($urandom_range(0, 1));
            cycle();
            ld   = 1'b0;
            step = 1'b0;
            model_load(int'(n));
            n_total++;
            if ({busy, result} !== {1'b0, P_W'(1)})
                $display("[TB] FAIL rand_load: got busy=%0b r=%0d want 0 1", busy, result);
            else n_pass++;
            if (m_a > 2 && $urandom_range(0, 2) == 0) begin
                step = 1'b1;
                cycle();
                step = 1'b0;
                repeat ($urandom_range(0, N_W)) cycle();
                do_load($urandom_range(2, 15));
            end
            run_to_completion();
        end
    endtask

    initial begin
        rst     = 1'b1;
        ld      = 1'b0;
        step    = 1'b0;
        n       = '0;
        n_pass  = 0;
        n_total = 0;
        #1;
        test_reset();
        test_fact5();
        test_small_n();
        test_latency();
        test_abort();
        test_overflow();
        test_reset_in_upd();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
